prog_feeder: RTL and testbench

PROG_FEEDER -- requirements
Module: prog_feeder

---
 rtl/prog_feeder_pkg.sv | 19 +
 rtl/prog_feeder_if.sv | 30 +++
 rtl/prog_feeder_mem.sv | 22 ++
 rtl/prog_feeder.sv | 159 +++++++++++++++
 tb/tb_prog_feeder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_feeder_pkg.sv
// rtl/prog_feeder_pkg.sv - shared processor package: feeder states, opcodes, sentinels
package prog_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_IMM,
        ST_ISSUE,
        ST_IMM,
        ST_WAIT_DONE,
        ST_HALT
    } state_e;

    localparam logic [2:0]  OP_MVI        = 3'b001;
    // All-ones word ends a program; consumers keep the low DATA_W bits.
    localparam logic [31:0] HALT_SENTINEL = 32'hFFFF_FFFF;
    localparam logic [7:0]  WDOG_LIMIT    = 8'd255;

endpackage

// File: rtl/prog_feeder_if.sv
// rtl/prog_feeder_if.sv - program-load write port and processor Din/run/done handshake
interface prog_feeder_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              done;
    logic [DATA_W-1:0] din;
    logic              run;

    modport master (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  done,
        output din,
        output run
    );

    modport slave (
        output wr_en,
        output wr_addr,
        output wr_data,
        output done,
        input  din,
        input  run
    );
endinterface

// File: rtl/prog_feeder_mem.sv
// rtl/prog_feeder_mem.sv - program memory: register array, one write port, synchronous read
module prog_mem #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Contents survive reset so a program can be rerun after an abort.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/prog_feeder.sv
// rtl/prog_feeder.sv - steps a stored program into a processor; watchdog under PROG_FEEDER_WDOG_EN
module prog_feeder
    import prog_feeder_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    prog_feeder_if.master     bus,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              error
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rd_data;
    logic              mem_we;
    logic              fetch_halt, fetch_mvi, instr_mvi;
    logic              wdog_trip;

    assign mem_we = bus.wr_en && (state_q == ST_IDLE || state_q == ST_HALT);

    // Reading at pc_d makes the word at pc ready in the state that consumes it.
    prog_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (bus.wr_addr),
        .wdata_i (bus.wr_data),
        .raddr_i (pc_d),
        .rdata_o (rd_data)
    );

    assign fetch_halt = (rd_data == HALT_SENTINEL[DATA_W-1:0]);
    assign fetch_mvi  = (rd_data[DATA_W-1 -: 3] == OP_MVI);
    assign instr_mvi  = (instr_q[DATA_W-1 -: 3] == OP_MVI);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        din_d   = din_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                instr_d = rd_data;
                if (fetch_halt) begin
                    state_d = ST_HALT;
                end else if (fetch_mvi) begin
                    state_d = ST_FETCH_IMM;
                    pc_d    = pc_q + 1'b1;
                end else begin
                    state_d = ST_ISSUE;
                    din_d   = rd_data;
                end
            end
            ST_FETCH_IMM: begin
                imm_d   = rd_data;
                state_d = ST_ISSUE;
                din_d   = instr_q;
            end
            ST_ISSUE: begin
                if (instr_mvi) begin
                    state_d = ST_IMM;
                    din_d   = imm_q;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_IMM: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.done) begin
                    if (pc_q == '1) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = pc_q + 1'b1;
                    end
                end else if (wdog_trip) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            din_q   <= din_d;
        end
    end

`ifdef PROG_FEEDER_WDOG_EN
    logic [7:0] wdog_q, wdog_d;
    logic       error_q, error_d;

    // Counter reads k in the k-th WAIT_DONE cycle, so the trip lands HALT 255 cycles after entry.
    assign wdog_trip = (state_q == ST_WAIT_DONE) && !bus.done && (wdog_q == WDOG_LIMIT - 8'd1);

    always_comb begin
        wdog_d  = (state_q == ST_WAIT_DONE) ? wdog_q + 8'd1 : 8'd0;
        error_d = error_q;
        if (wdog_trip) begin
            error_d = 1'b1;
        end else if (start && (state_q == ST_IDLE || state_q == ST_HALT)) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q  <= 8'd0;
            error_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign wdog_trip = 1'b0;
    assign error     = 1'b0;
`endif

    assign bus.din = din_q;
    assign bus.run = (state_q == ST_ISSUE);
    assign pc      = pc_q;
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted  = (state_q == ST_HALT);
endmodule

// File: tb/tb_prog_feeder.sv
// tb/tb_prog_feeder.sv - randomized program runs against a program-walk reference model
module tb_prog_feeder;
    localparam int DW    = 9;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] pc;
    logic          busy, halted, error;

    prog_feeder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    prog_feeder #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bus    (bus.master),
        .pc     (pc),
        .busy   (busy),
        .halted (halted),
        .error  (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] instr;
        bit            mvi;
        logic [DW-1:0] imm;
    } issue_t;

    int            n_pass  = 0;
    int            n_total = 0;
    logic [DW-1:0] model_mem [DEPTH];
    issue_t        exp_q [$];
    int            exp_halt_pc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic write_word(input int a, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic load_random(input int halt_at);
        logic [DW-1:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = DW'($urandom_range(0, 511));
            if (i < DEPTH - 1 && $urandom_range(0, 3) == 0) w[8:6] = 3'b001;
            if (i == DEPTH - 1 && w[8:6] == 3'b001) w[8:6] = 3'b000;
            if (w == 9'h1FF) w = 9'h1FE;
            if (i == halt_at) w = 9'h1FF;
            write_word(i, w);
        end
    endtask

    // Walk the program as the processor sees it: issued words in order, then the halt address.
    task automatic build_trace();
        int            p;
        logic [DW-1:0] w;
        issue_t        it;
        p = 0;
        exp_q.delete();
        exp_halt_pc = -1;
        for (int n = 0; n < 4 * DEPTH; n++) begin
            w = model_mem[p];
            if (w == 9'h1FF) begin
                exp_halt_pc = p;
                return;
            end
            it.instr = w;
            it.mvi   = (w[8:6] == 3'b001);
            it.imm   = '0;
            if (it.mvi) begin
                p      = (p + 1) % DEPTH;
                it.imm = model_mem[p];
            end
            exp_q.push_back(it);
            if (p == DEPTH - 1) begin
                exp_halt_pc = p;
                return;
            end
            p = p + 1;
        end
    endtask

    task automatic run_program(input bit intrude, input string tag);
        int     cyc;
        issue_t it;
        build_trace();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            it  = exp_q[k];
            cyc = 1;
            while (bus.run !== 1'b1 && cyc < 8) begin
                step();
                cyc++;
            end
            if (k == 0) chk({tag, " latency"}, cyc, it.mvi ? 3 : 2);
            chk({tag, " run"}, bus.run, 1'b1);
            chk({tag, " instr"}, bus.din, it.instr);
            if (bus.run !== 1'b1) return;
            if (intrude || $urandom_range(0, 1) == 1) bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            if (it.mvi) begin
                chk({tag, " imm"}, bus.din, it.imm);
                chk({tag, " imm run"}, bus.run, 1'b0);
                step();
            end
            repeat ($urandom_range(0, 3)) begin
                chk({tag, " wait busy"}, busy, 1'b1);
                chk({tag, " wait run"}, bus.run, 1'b0);
                chk({tag, " wait din"}, bus.din, it.mvi ? it.imm : it.instr);
                step();
            end
            if (intrude && k == 0) begin
                start       = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = '0;
                bus.wr_data = ~model_mem[0];
                step();
                start     = 1'b0;
                bus.wr_en = 1'b0;
                chk({tag, " intrude busy"}, busy, 1'b1);
                chk({tag, " intrude run"}, bus.run, 1'b0);
            end
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
        end
        cyc = 0;
        while (halted !== 1'b1 && cyc < 8) begin
            step();
            cyc++;
        end
        chk({tag, " halted"}, halted, 1'b1);
        chk({tag, " halt pc"}, pc, exp_halt_pc);
        chk({tag, " halt busy"}, busy, 1'b0);
        chk({tag, " halt run"}, bus.run, 1'b0);
        chk({tag, " halt error"}, error, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.done    = 1'b0;
        step();
        step();
        chk("reset pc", pc, 0);
        chk("reset din", bus.din, 0);
        chk("reset run", bus.run, 0);
        chk("reset busy", busy, 0);
        chk("reset halted", halted, 0);
        chk("reset error", error, 0);
        reset = 1'b0;
        step();

        write_word(0, 9'h010);
        write_word(1, 9'h1FF);
        run_program(1'b0, "mv");

        write_word(0, 9'h040);
        write_word(1, 9'h005);
        write_word(2, 9'h1FF);
        run_program(1'b0, "mvi");

        load_random(-1);
        run_program(1'b0, "full");
        repeat (3) begin
            step();
            chk("full nowrap run", bus.run, 1'b0);
            chk("full nowrap pc", pc, DEPTH - 1);
        end

        write_word(0, 9'h040);
        write_word(1, 9'h005);
        write_word(2, 9'h1FF);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("midreset run", bus.run, 0);
        chk("midreset busy", busy, 0);
        chk("midreset pc", pc, 0);
        chk("midreset din", bus.din, 0);
        chk("midreset halted", halted, 0);
        step();
        reset = 1'b0;
        step();
        run_program(1'b0, "rerun");

        load_random($urandom_range(4, DEPTH - 1));
        run_program(1'b1, "intrude");
        run_program(1'b0, "after intrude");

        for (int r = 0; r < 4; r++) begin
            load_random($urandom_range(0, DEPTH + 8));
            run_program(1'b0, $sformatf("rand%0d", r));
        end

`ifdef PROG_FEEDER_WDOG_EN
        write_word(0, 9'h010);
        write_word(1, 9'h1FF);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("wdog run", bus.run, 1'b1);
        step();
        repeat (254) step();
        chk("wdog early halted", halted, 1'b0);
        chk("wdog early busy", busy, 1'b1);
        step();
        chk("wdog halted", halted, 1'b1);
        chk("wdog error", error, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("wdog error cleared", error, 1'b0);
        chk("wdog restart busy", busy, 1'b1);
        step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        repeat (3) step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
